// File: rtl/sys_bridge_n.sv
// CPU data-port bridge: decodes memory, N device windows, the interrupt generator
// and a local status window; keeps W1C interrupt-pending bits and a sticky fault record.
module sys_bridge_n #(
  parameter int unsigned N_DEV      = 2,
  parameter logic [31:0] DEV_BASE   = 32'h0000_7F00,
  parameter logic [31:0] DEV_STRIDE = 32'h0000_0010,
  parameter int unsigned DEV_SPAN   = 12,
  parameter logic [31:0] INT_ADDR   = 32'h0000_7F20,
  parameter logic [31:0] STAT_ADDR  = 32'h0000_7F40,
  parameter logic [31:0] MEM_LIMIT  = 32'h0000_2FFF,
  parameter bit          RD_REG     = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  input  logic [3:0]           cpu_byteen,
  input  logic                 cpu_we,
  input  logic                 cpu_re,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_rvalid,
  output logic [31:0]          m_data_addr,
  output logic [31:0]          m_data_wdata,
  output logic [3:0]           m_data_byteen,
  input  logic [31:0]          m_data_rdata,
  output logic [31:0]          m_int_addr,
  output logic [3:0]           m_int_byteen,
  output logic [31:0]          dev_addr,
  output logic [31:0]          dev_wdata,
  output logic [N_DEV-1:0]     dev_we,
  input  logic [32*N_DEV-1:0]  dev_rdata,
  input  logic [N_DEV-1:0]     dev_irq,
  output logic [N_DEV-1:0]     hw_int,
  output logic                 fault
);

  localparam int unsigned IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

  typedef enum logic [2:0] {
    REG_MEM,
    REG_DEV,
    REG_INT,
    REG_STAT,
    REG_NONE
  } region_e;

  region_e          region;
  logic [IDX_W-1:0] dev_idx;
  logic [31:0]      dev_base;
  logic             access;
  logic             bad_form;
  logic             illegal;
  logic             wr_ok;
  logic             stat_w0;
  logic             stat_w1;
  logic             stat_w2;
  logic [31:0]      rd_mux;

  logic [N_DEV-1:0] irq_prev_q;
  logic [N_DEV-1:0] irq_pend_q;
  logic [N_DEV-1:0] irq_pend_d;
  logic [N_DEV-1:0] irq_clr;
  logic             fault_q;
  logic             fault_d;
  logic [31:0]      fault_addr_q;
  logic [31:0]      fault_addr_d;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    region   = REG_NONE;
    dev_idx  = '0;
    dev_base = DEV_BASE;
    if (cpu_addr <= MEM_LIMIT) begin
      region = REG_MEM;
    end else begin
      // Lowest-numbered window wins if windows were ever configured to overlap.
      for (int unsigned i = 0; i < N_DEV; i++) begin
        dev_base = DEV_BASE + DEV_STRIDE * 32'(i);
        if (region == REG_NONE && cpu_addr >= dev_base &&
            cpu_addr < dev_base + 32'(DEV_SPAN)) begin
          region  = REG_DEV;
          dev_idx = IDX_W'(i);
        end
      end
      if (region == REG_NONE && cpu_addr >= INT_ADDR && cpu_addr <= INT_ADDR + 32'd3) begin
        region = REG_INT;
      end else if (region == REG_NONE && cpu_addr >= STAT_ADDR &&
                   cpu_addr <= STAT_ADDR + 32'd11) begin
        region = REG_STAT;
      end
    end
  end

  assign stat_w0  = (cpu_addr == STAT_ADDR);
  assign stat_w1  = (cpu_addr == STAT_ADDR + 32'd4);
  assign stat_w2  = (cpu_addr == STAT_ADDR + 32'd8);
  assign access   = cpu_we | cpu_re;
  assign bad_form = (region == REG_DEV || region == REG_STAT) &&
                    (cpu_addr[1:0] != 2'b00 || (cpu_we && cpu_byteen != 4'b1111));
  assign illegal  = access && (region == REG_NONE || bad_form);
  assign wr_ok    = cpu_we && !illegal;

  assign m_data_addr   = cpu_addr;
  assign m_data_wdata  = cpu_wdata;
  assign m_int_addr    = cpu_addr;
  assign dev_addr      = cpu_addr;
  assign dev_wdata     = cpu_wdata;
  assign m_data_byteen = (cpu_we && region == REG_MEM) ? cpu_byteen : 4'b0000;
  assign m_int_byteen  = (wr_ok && region == REG_INT) ? 4'b0001 : 4'b0000;

  always_comb begin
    dev_we = '0;
    if (wr_ok && region == REG_DEV) dev_we[dev_idx] = 1'b1;
  end

  always_comb begin
    rd_mux = 32'h0;
    case (region)
      REG_MEM: rd_mux = m_data_rdata;
      REG_DEV: rd_mux = dev_rdata[32*int'(dev_idx) +: 32];
      REG_STAT: begin
        if (stat_w0)      rd_mux = 32'(irq_pend_q);
        else if (stat_w1) rd_mux = {31'b0, fault_q};
        else if (stat_w2) rd_mux = fault_addr_q;
      end
      default: rd_mux = 32'h0;
    endcase
  end

  // A fresh rising edge beats a W1C clear of the same bit.
  assign irq_clr    = (wr_ok && region == REG_STAT && stat_w0) ? cpu_wdata[N_DEV-1:0] : '0;
  assign irq_pend_d = (irq_pend_q & ~irq_clr) | (dev_irq & ~irq_prev_q);

  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (illegal) begin
      fault_d = 1'b1;
      if (!fault_q) fault_addr_d = cpu_addr;
    end else if (wr_ok && region == REG_STAT && stat_w1 && cpu_wdata[0]) begin
      fault_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev_q   <= '0;
      irq_pend_q   <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
    end else begin
      irq_prev_q   <= dev_irq;
      irq_pend_q   <= irq_pend_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign hw_int = irq_pend_q;
  assign fault  = fault_q;

  if (RD_REG) begin : g_rd_reg
    logic        rvalid_q;
    logic        rd_mem_q;
    logic [31:0] rd_data_q;
    logic [31:0] rdata_hold_q;
    logic [31:0] rdata_out;

    // Memory responds a cycle late, so its data is taken live in the response cycle.
    assign rdata_out = rvalid_q ? (rd_mem_q ? m_data_rdata : rd_data_q) : rdata_hold_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        rvalid_q     <= 1'b0;
        rd_mem_q     <= 1'b0;
        rd_data_q    <= 32'h0;
        rdata_hold_q <= 32'h0;
      end else begin
        rvalid_q     <= cpu_re;
        rdata_hold_q <= rdata_out;
        if (cpu_re) begin
          rd_mem_q  <= (region == REG_MEM);
          rd_data_q <= rd_mux;
        end
      end
    end

    assign cpu_rdata  = rdata_out;
    assign cpu_rvalid = rvalid_q;
  end else begin : g_rd_comb
    assign cpu_rdata  = rd_mux;
    assign cpu_rvalid = cpu_re;
  end

endmodule

// File: tb/tb_sys_bridge_n.sv
// Bench for sys_bridge_n: vector table over decode, enables, status and faults, with a
// read-response scoreboard on the registered instance plus reset-during-read sequences.
module tb_sys_bridge_n;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, m_data_rdata;
  logic [3:0]  cpu_byteen;
  logic        cpu_we, cpu_re;
  logic [63:0] dev_rdata;
  logic [1:0]  dev_irq;

  logic [31:0] cpu_rdata, m_data_addr, m_data_wdata, m_int_addr, dev_addr, dev_wdata;
  logic [3:0]  m_data_byteen, m_int_byteen;
  logic [1:0]  dev_we, hw_int;
  logic        cpu_rvalid, fault;

  logic [31:0] cpu_rdata_c, m_data_addr_c, m_data_wdata_c, m_int_addr_c, dev_addr_c, dev_wdata_c;
  logic [3:0]  m_data_byteen_c, m_int_byteen_c;
  logic [1:0]  dev_we_c, hw_int_c;
  logic        cpu_rvalid_c, fault_c;

  always #5 clk = ~clk;

  sys_bridge_n #(.N_DEV(2), .RD_REG(1'b1)) u_dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_byteen(cpu_byteen), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .m_data_rdata(m_data_rdata), .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_we(dev_we), .dev_rdata(dev_rdata),
    .dev_irq(dev_irq), .hw_int(hw_int), .fault(fault)
  );

  sys_bridge_n #(.N_DEV(2), .RD_REG(1'b0)) u_dut_c (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_byteen(cpu_byteen), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata_c), .cpu_rvalid(cpu_rvalid_c),
    .m_data_addr(m_data_addr_c), .m_data_wdata(m_data_wdata_c), .m_data_byteen(m_data_byteen_c),
    .m_data_rdata(m_data_rdata), .m_int_addr(m_int_addr_c), .m_int_byteen(m_int_byteen_c),
    .dev_addr(dev_addr_c), .dev_wdata(dev_wdata_c), .dev_we(dev_we_c), .dev_rdata(dev_rdata),
    .dev_irq(dev_irq), .hw_int(hw_int_c), .fault(fault_c)
  );

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [1:0]  irq;
    logic [1:0]  e_dev_we;
    logic [3:0]  e_mbe;
    logic [3:0]  e_ibe;
    logic [31:0] e_rdata;
    logic [1:0]  e_hw;
    logic        e_fault;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata = 32'h0;
  logic        mon_re, mon_rst;
  vec_t        vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic re, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic [1:0] irq, input logic [1:0] dwe,
                              input logic [3:0] mbe, input logic [3:0] ibe,
                              input logic [31:0] rd, input logic [1:0] hw, input logic flt);
    vec_t v;
    v.we = we; v.re = re; v.addr = addr; v.wdata = wdata; v.be = be; v.irq = irq;
    v.e_dev_we = dwe; v.e_mbe = mbe; v.e_ibe = ibe; v.e_rdata = rd; v.e_hw = hw;
    v.e_fault = flt;
    return v;
  endfunction

  // Response monitor for the registered-read instance.
  always @(posedge clk) begin
    mon_re  = cpu_re;
    mon_rst = reset;
    #1;
    if (mon_rst) begin
      exp_q.delete();
      last_rdata = 32'h0;
      check("rvalid after reset", 32'(cpu_rvalid), 32'h0);
      check("rdata after reset", cpu_rdata, 32'h0);
    end else begin
      check("rvalid timing", 32'(cpu_rvalid), 32'(mon_re));
      if (cpu_rvalid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rdata: got response %h expected none", cpu_rdata);
        end else begin
          last_rdata = exp_q.pop_front();
          check("rdata", cpu_rdata, last_rdata);
        end
      end else begin
        check("rdata hold", cpu_rdata, last_rdata);
      end
    end
  end

  task automatic set_idle();
    cpu_we     = 1'b0;
    cpu_re     = 1'b0;
    cpu_addr   = 32'h0000_0100;
    cpu_wdata  = 32'h0;
    cpu_byteen = 4'h0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    cpu_we = v.we; cpu_re = v.re; cpu_addr = v.addr; cpu_wdata = v.wdata;
    cpu_byteen = v.be; dev_irq = v.irq;
    if (v.re) exp_q.push_back(v.e_rdata);
    #2;
    check($sformatf("v%0d dev_we", idx), 32'(dev_we), 32'(v.e_dev_we));
    check($sformatf("v%0d m_data_byteen", idx), 32'(m_data_byteen), 32'(v.e_mbe));
    check($sformatf("v%0d m_int_byteen", idx), 32'(m_int_byteen), 32'(v.e_ibe));
    check($sformatf("v%0d dev_addr", idx), dev_addr, v.addr);
    check($sformatf("v%0d m_data_wdata", idx), m_data_wdata, v.wdata);
    check($sformatf("v%0d comb rvalid", idx), 32'(cpu_rvalid_c), 32'(v.re));
    if (v.re) check($sformatf("v%0d comb rdata", idx), cpu_rdata_c, v.e_rdata);
    @(posedge clk);
    #2;
    check($sformatf("v%0d hw_int", idx), 32'(hw_int), 32'(v.e_hw));
    check($sformatf("v%0d fault", idx), 32'(fault), 32'(v.e_fault));
  endtask

  initial begin
    reset        = 1'b1;
    dev_irq      = 2'b00;
    m_data_rdata = 32'h0000_DEAD;
    dev_rdata    = {32'h0000_1234, 32'hCAFE_0000};
    set_idle();
    repeat (2) @(posedge clk);
    #2;
    check("reset hw_int", 32'(hw_int), 32'h0);
    check("reset fault", 32'(fault), 32'h0);
    check("reset rvalid", 32'(cpu_rvalid), 32'h0);
    check("reset rdata", cpu_rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    //                 we re addr           wdata          be    irq   dwe   mbe   ibe   rdata          hw    flt
    vecs.push_back(mk(1, 0, 32'h0000_7F14, 32'h0000_00A5, 4'hF, 2'b00, 2'b10, 4'h0, 4'h0, 32'h0,         2'b00, 0));
    vecs.push_back(mk(0, 1, 32'h0000_7F14, 32'h0,         4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0000_1234, 2'b00, 0));
    vecs.push_back(mk(0, 1, 32'h0000_0010, 32'h0,         4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0000_DEAD, 2'b00, 0));
    vecs.push_back(mk(1, 0, 32'h0000_0011, 32'h0000_5500, 4'h2, 2'b00, 2'b00, 4'h2, 4'h0, 32'h0,         2'b00, 0));
    vecs.push_back(mk(1, 0, 32'h0000_7F20, 32'h0000_0001, 4'hF, 2'b00, 2'b00, 4'h0, 4'h1, 32'h0,         2'b00, 0));
    vecs.push_back(mk(0, 1, 32'h0000_7F20, 32'h0,         4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0,         2'b00, 0));
    vecs.push_back(mk(0, 1, 32'h0000_7F04, 32'h0,         4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 32'hCAFE_0000, 2'b00, 0));
    vecs.push_back(mk(1, 0, 32'h0000_7F0C, 32'h0000_00FF, 4'hF, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0,         2'b00, 1));
    vecs.push_back(mk(1, 0, 32'h0000_7F00, 32'h0000_00FF, 4'h3, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0,         2'b00, 1));
    vecs.push_back(mk(0, 1, 32'h0000_7F48, 32'h0,         4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0000_7F0C, 2'b00, 1));
    vecs.push_back(mk(0, 1, 32'h0000_7F44, 32'h0,         4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0000_0001, 2'b00, 1));
    vecs.push_back(mk(1, 0, 32'h0000_7F44, 32'h0000_0001, 4'hF, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0,         2'b00, 0));
    vecs.push_back(mk(0, 1, 32'h0000_7F48, 32'h0,         4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0000_7F0C, 2'b00, 0));
    vecs.push_back(mk(0, 1, 32'h0000_7F0A, 32'h0,         4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 32'hCAFE_0000, 2'b00, 1));
    vecs.push_back(mk(0, 1, 32'h0000_7F48, 32'h0,         4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0000_7F0A, 2'b00, 1));
    vecs.push_back(mk(1, 0, 32'h0000_7F44, 32'h0000_0001, 4'hF, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0,         2'b00, 0));
    vecs.push_back(mk(0, 1, 32'h0000_5000, 32'h0,         4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0,         2'b00, 1));
    vecs.push_back(mk(1, 0, 32'h0000_7F44, 32'h0000_0001, 4'hF, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0,         2'b00, 0));
    vecs.push_back(mk(1, 0, 32'h0000_7F18, 32'h0000_0005, 4'hF, 2'b00, 2'b10, 4'h0, 4'h0, 32'h0,         2'b00, 0));
    vecs.push_back(mk(1, 0, 32'h0000_7F1C, 32'h0000_0005, 4'hF, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0,         2'b00, 1));
    vecs.push_back(mk(1, 0, 32'h0000_7F44, 32'h0000_0001, 4'hF, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0,         2'b00, 0));
    vecs.push_back(mk(1, 0, 32'h0000_2FFF, 32'h0,         4'h8, 2'b00, 2'b00, 4'h8, 4'h0, 32'h0,         2'b00, 0));
    vecs.push_back(mk(1, 0, 32'h0000_3000, 32'h0,         4'hF, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0,         2'b00, 1));
    vecs.push_back(mk(1, 0, 32'h0000_7F44, 32'h0000_0001, 4'hF, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0,         2'b00, 0));
    vecs.push_back(mk(1, 0, 32'h0000_7F23, 32'h0,         4'hF, 2'b00, 2'b00, 4'h0, 4'h1, 32'h0,         2'b00, 0));
    vecs.push_back(mk(0, 1, 32'h0000_7F4C, 32'h0,         4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0,         2'b00, 1));
    vecs.push_back(mk(1, 0, 32'h0000_7F44, 32'h0000_0001, 4'hF, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0,         2'b00, 0));
    vecs.push_back(mk(0, 0, 32'h0000_0100, 32'h0,         4'h0, 2'b01, 2'b00, 4'h0, 4'h0, 32'h0,         2'b01, 0));
    vecs.push_back(mk(1, 0, 32'h0000_7F40, 32'h0000_0001, 4'hF, 2'b01, 2'b00, 4'h0, 4'h0, 32'h0,         2'b00, 0));
    vecs.push_back(mk(0, 0, 32'h0000_0100, 32'h0,         4'h0, 2'b01, 2'b00, 4'h0, 4'h0, 32'h0,         2'b00, 0));
    vecs.push_back(mk(1, 0, 32'h0000_7F40, 32'h0000_0003, 4'hF, 2'b11, 2'b00, 4'h0, 4'h0, 32'h0,         2'b10, 0));
    vecs.push_back(mk(0, 1, 32'h0000_7F40, 32'h0,         4'h0, 2'b11, 2'b00, 4'h0, 4'h0, 32'h0000_0002, 2'b10, 0));
    vecs.push_back(mk(1, 0, 32'h0000_7F40, 32'h0000_0002, 4'hF, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0,         2'b00, 0));
    vecs.push_back(mk(1, 0, 32'h0000_7F44, 32'h0000_0001, 4'h7, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0,         2'b00, 1));
    vecs.push_back(mk(0, 1, 32'h0000_7F48, 32'h0,         4'h0, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0000_7F44, 2'b00, 1));
    vecs.push_back(mk(1, 0, 32'h0000_7F44, 32'h0000_0001, 4'hF, 2'b00, 2'b00, 4'h0, 4'h0, 32'h0,         2'b00, 0));

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Reset one cycle after a read strobe, with a pending irq and a fault outstanding.
    @(negedge clk);
    set_idle();
    dev_irq = 2'b01;
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = 32'h0000_5000; cpu_byteen = 4'hF;
    @(negedge clk);
    set_idle();
    cpu_re = 1'b1; cpu_addr = 32'h0000_7F14;
    exp_q.push_back(32'h0000_1234);
    @(posedge clk);
    #2;
    check("pre-reset hw_int", 32'(hw_int), 32'h1);
    check("pre-reset fault", 32'(fault), 32'h1);
    @(negedge clk);
    set_idle();
    reset   = 1'b1;
    dev_irq = 2'b00;
    @(posedge clk);
    #2;
    check("post-reset hw_int", 32'(hw_int), 32'h0);
    check("post-reset fault", 32'(fault), 32'h0);

    // Read strobe coinciding with reset: its response must be dropped.
    @(negedge clk);
    cpu_re = 1'b1; cpu_addr = 32'h0000_7F14;
    exp_q.push_back(32'h0000_1234);
    @(posedge clk);
    #2;
    check("dropped read rvalid", 32'(cpu_rvalid), 32'h0);
    @(negedge clk);
    reset  = 1'b0;
    cpu_re = 1'b1; cpu_addr = 32'h0000_7F48;
    exp_q.push_back(32'h0);
    @(negedge clk);
    set_idle();
    @(negedge clk);
    @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
